// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ byte producers.
// Grants per message, issues one write strobe per byte, and paces bytes on tx_busy.
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16,
  parameter int START_TO  = 4
) (
  input  logic                    clk_50m,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] din,
  input  logic [N_REQ-1:0]        last,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        ack,
  output logic                    tx_wr_en,
  output logic [DATA_W-1:0]       tx_din,
  input  logic                    tx_busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TO_W  = (START_TO > 1) ? $clog2(START_TO + 1) : 1;
  localparam logic [7:0]      BURST_MAX = 8'(MAX_BURST);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(START_TO - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_START, WAIT_DONE} state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               tx_wr_en_q, tx_wr_en_d;
  logic [DATA_W-1:0]  tx_din_q, tx_din_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               last_q, last_d;
  logic [TO_W-1:0]    to_q, to_d;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               done_now;
  logic               rel_now;
  int                 cand;

  // Scan ptr+1, ptr+2, ... so the previous owner is considered last.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = (int'(ptr_q) + i) % N_REQ;
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ack_d      = '0;
    tx_wr_en_d = 1'b0;
    tx_din_d   = tx_din_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    to_d       = to_q;
    done_now   = 1'b0;
    rel_now    = 1'b0;

    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (pick_valid) begin
          owner_d = pick_idx;
          grant_d = N_REQ'(1) << pick_idx;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!req[owner_q]) begin
          rel_now = 1'b1;
        end else if (!tx_busy) begin
          tx_wr_en_d = 1'b1;
          ack_d      = N_REQ'(1) << owner_q;
          tx_din_d   = din[owner_q*DATA_W +: DATA_W];
          last_d     = last[owner_q];
          cnt_d      = cnt_q + 8'd1;
          to_d       = '0;
          state_d    = WAIT_START;
        end
      end
      // A transmitter that never raises busy must not stall the arbiter forever.
      WAIT_START: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (to_q == TO_LAST) begin
          done_now = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          done_now = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (done_now) begin
      if (last_q || cnt_q == BURST_MAX || !req[owner_q]) begin
        rel_now = 1'b1;
      end else begin
        state_d = SEND;
      end
    end

    if (rel_now) begin
      grant_d = '0;
      ptr_d   = owner_q;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      ack_q      <= '0;
      tx_wr_en_q <= 1'b0;
      tx_din_q   <= '0;
      owner_q    <= '0;
      ptr_q      <= IDX_W'(N_REQ - 1);
      cnt_q      <= '0;
      last_q     <= 1'b0;
      to_q       <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      tx_wr_en_q <= tx_wr_en_d;
      tx_din_q   <= tx_din_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      to_q       <= to_d;
    end
  end

  assign grant    = grant_q;
  assign ack      = ack_q;
  assign tx_wr_en = tx_wr_en_q;
  assign tx_din   = tx_din_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester and transmitter models drive the DUT,
// a monitor pops the expected (owner, byte) pair on every write strobe.
module tb_uart_tx_arbiter;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } exp_t;

  logic                    clk_50m = 1'b0;
  logic                    rst;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] din;
  logic [N_REQ-1:0]        last;
  logic [N_REQ-1:0]        grant;
  logic [N_REQ-1:0]        ack;
  logic                    tx_wr_en;
  logic [DATA_W-1:0]       tx_din;
  logic                    tx_busy;

  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   strobes    = 0;
  int   last_strobe_cyc = 0;
  int   prev_strobe_cyc = 0;
  int   busy_cnt   = 0;
  int   tx_mode    = 0;
  logic [N_REQ-1:0] grant_prev = '0;

  logic [8:0] rbuf [N_REQ][64];
  int         rhead [N_REQ];
  int         rtail [N_REQ];
  exp_t       expq [$];

  uart_tx_arbiter #(
    .N_REQ(4), .DATA_W(8), .MAX_BURST(16), .START_TO(4)
  ) dut (
    .clk_50m (clk_50m),
    .rst     (rst),
    .req     (req),
    .din     (din),
    .last    (last),
    .grant   (grant),
    .ack     (ack),
    .tx_wr_en(tx_wr_en),
    .tx_din  (tx_din),
    .tx_busy (tx_busy)
  );

  always #10 clk_50m = ~clk_50m;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input int r, input logic [7:0] data, input logic is_last);
    rbuf[r][rtail[r]] = {is_last, data};
    rtail[r]++;
  endtask

  task automatic expectByte(input int r, input logic [7:0] data);
    exp_t e;
    e.idx  = 2'(r);
    e.data = data;
    expq.push_back(e);
  endtask

  task automatic clearAll();
    for (int i = 0; i < N_REQ; i++) begin
      rhead[i] = 0;
      rtail[i] = 0;
    end
    expq.delete();
    req     = '0;
    din     = '0;
    last    = '0;
    tx_mode = 0;
  endtask

  task automatic doReset();
    @(posedge clk_50m); #2;
    rst = 1'b1;
    clearAll();
    repeat (2) @(posedge clk_50m);
    #2;
    rst = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int budget);
    int  n  = 0;
    bit  ok = 1'b0;
    bit  empty;
    while (!ok && n < budget) begin
      @(posedge clk_50m); #2;
      n++;
      empty = 1'b1;
      for (int i = 0; i < N_REQ; i++) if (rhead[i] != rtail[i]) empty = 1'b0;
      if (empty && expq.size() == 0 && grant == '0) ok = 1'b1;
    end
    checkOutput({name, "_drained"}, 32'(ok), 32'd1);
    repeat (2) @(posedge clk_50m);
    #2;
  endtask

  // Monitor, transmitter model and requester models share one process so their order is fixed.
  initial begin
    forever begin
      @(negedge clk_50m);
      cyc++;
      if (rst) begin
        busy_cnt   = 0;
        tx_busy    = 1'b0;
        grant_prev = '0;
      end else begin
        if (grant_prev != '0 && grant != grant_prev) checkOutput("idle_gap", 32'(grant), 32'd0);
        grant_prev = grant;
        if (tx_wr_en) begin
          strobes++;
          prev_strobe_cyc = last_strobe_cyc;
          last_strobe_cyc = cyc;
          checkOutput("busy_at_strobe", 32'(tx_busy), 32'd0);
          if (expq.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_strobe: got tx_din 0x%0h, expected no strobe", tx_din);
          end else begin
            exp_t e;
            e = expq.pop_front();
            checkOutput("tx_din", 32'(tx_din), 32'(e.data));
            checkOutput("ack", 32'(ack), 32'(1) << e.idx);
            checkOutput("grant", 32'(grant), 32'(1) << e.idx);
          end
        end else begin
          checkOutput("ack_without_strobe", 32'(ack), 32'd0);
        end
        case (tx_mode)
          1: tx_busy = 1'b1;
          2: tx_busy = 1'b0;
          default: begin
            if (tx_wr_en) busy_cnt = 3;
            else if (busy_cnt > 0) busy_cnt--;
            tx_busy = (busy_cnt != 0);
          end
        endcase
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!rst && ack[i] && rhead[i] != rtail[i]) rhead[i]++;
        if (rhead[i] != rtail[i]) begin
          req[i]             = 1'b1;
          din[i*DATA_W +: 8] = rbuf[i][rhead[i]][7:0];
          last[i]            = rbuf[i][rhead[i]][8];
        end else begin
          req[i]             = 1'b0;
          din[i*DATA_W +: 8] = 8'h00;
          last[i]            = 1'b0;
        end
      end
    end
  end

  initial begin
    int n;
    int s0;
    rst     = 1'b1;
    tx_busy = 1'b0;
    clearAll();
    repeat (3) @(posedge clk_50m);
    #2;
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_wr_en", 32'(tx_wr_en), 32'd0);
    checkOutput("rst_tx_din", 32'(tx_din), 32'd0);
    rst = 1'b0;

    // Reset asserted while the DUT waits for the transmitter to finish.
    applyStimulus(2, 8'h5A, 1'b1);
    expectByte(2, 8'h5A);
    n = 0;
    while (strobes == 0 && n < 50) begin
      @(posedge clk_50m); #2;
      n++;
    end
    checkOutput("t1_strobe_seen", 32'(strobes != 0), 32'd1);
    @(posedge clk_50m); #2;
    checkOutput("t1_grant_in_wait", 32'(grant), 32'h4);
    rst = 1'b1;
    #1;
    checkOutput("t1_async_grant", 32'(grant), 32'd0);
    checkOutput("t1_async_ack", 32'(ack), 32'd0);
    checkOutput("t1_async_wr_en", 32'(tx_wr_en), 32'd0);
    checkOutput("t1_async_tx_din", 32'(tx_din), 32'd0);
    clearAll();
    repeat (2) @(posedge clk_50m);
    #2;
    rst = 1'b0;
    for (int r = 0; r < N_REQ; r++) begin
      applyStimulus(r, 8'h10 + 8'(r), 1'b1);
      expectByte(r, 8'h10 + 8'(r));
    end
    waitDrain("t1_all_req", 300);

    // Single three-byte message from requester 2.
    doReset();
    s0 = strobes;
    applyStimulus(2, 8'h41, 1'b0);
    applyStimulus(2, 8'h42, 1'b0);
    applyStimulus(2, 8'h43, 1'b1);
    expectByte(2, 8'h41);
    expectByte(2, 8'h42);
    expectByte(2, 8'h43);
    waitDrain("t2_message", 300);
    checkOutput("t2_strobe_count", 32'(strobes - s0), 32'd3);

    // Round-robin among requesters 0, 1 and 3 with one-byte messages.
    doReset();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 8'h60 + 8'(k*4), 1'b1);
      applyStimulus(1, 8'h61 + 8'(k*4), 1'b1);
      applyStimulus(3, 8'h63 + 8'(k*4), 1'b1);
    end
    expectByte(0, 8'h60); expectByte(1, 8'h61); expectByte(3, 8'h63);
    expectByte(0, 8'h64); expectByte(1, 8'h65); expectByte(3, 8'h67);
    waitDrain("t3_round_robin", 400);

    // Burst cap: requester 1 loses the grant after 16 bytes, requester 3 goes next.
    doReset();
    for (int b = 0; b < 20; b++) applyStimulus(1, 8'h80 + 8'(b), 1'b0);
    applyStimulus(3, 8'hC3, 1'b1);
    for (int b = 0; b < 16; b++) expectByte(1, 8'h80 + 8'(b));
    expectByte(3, 8'hC3);
    for (int b = 16; b < 20; b++) expectByte(1, 8'h80 + 8'(b));
    waitDrain("t4_burst_cap", 1500);

    // Busy held high blocks the strobe; busy never rising falls back on the timeout.
    doReset();
    tx_mode = 1;
    s0 = strobes;
    applyStimulus(2, 8'h77, 1'b1);
    expectByte(2, 8'h77);
    repeat (12) @(posedge clk_50m);
    #2;
    checkOutput("t5_no_strobe_while_busy", 32'(strobes - s0), 32'd0);
    checkOutput("t5_grant_held", 32'(grant), 32'h4);
    tx_mode = 0;
    waitDrain("t5_busy_release", 200);
    tx_mode = 2;
    applyStimulus(0, 8'hA1, 1'b0);
    applyStimulus(0, 8'hA2, 1'b1);
    expectByte(0, 8'hA1);
    expectByte(0, 8'hA2);
    waitDrain("t5_timeout", 200);
    checkOutput("t5_timeout_gap", 32'(last_strobe_cyc - prev_strobe_cyc), 32'd5);
    tx_mode = 0;

    // Requester 0 drops mid-message; requester 1 must follow.
    doReset();
    applyStimulus(0, 8'hE1, 1'b0);
    applyStimulus(0, 8'hE2, 1'b0);
    applyStimulus(1, 8'hF1, 1'b1);
    expectByte(0, 8'hE1);
    expectByte(0, 8'hE2);
    expectByte(1, 8'hF1);
    waitDrain("t6_drop", 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
